apb_master: RTL and testbench
=============================

# apb_master

- Single-outstanding APB requester: the initiating end of the APB link into the `ann` accelerator.
- Takes one read or write command at a time on a valid/ready command port and runs it as a SETUP/ACCESS transfer.
- Returns read data and the slave error flag on a valid/ready response port.
- Sits between the host-side sequencer (weight/input loader, result reader) and the `ann` APB slave port.

## Interface
Parameters:
- ADDR_WIDTH, 8: APB address width; matches the ann slave.
- WORD_SIZE, 16: APB data width.
- TIMEOUT_CYCLES, 16: ACCESS cycles allowed with pready low; used only under APB_MASTER_TIMEOUT_EN. Legal range is 1 or more.

Ports:
- One clock; reset is synchronous and active-high. All outputs are registered unless stated otherwise.
- clk_i  in  1  clock; all logic on the rising edge.
- rst_i  in  1  synchronous, active-high reset.
- cmd_valid_i  in  1  a command is offered.
- cmd_ready_o  out  1  the block can accept a command.
- cmd_write_i  in  1  1 = write, 0 = read.
- cmd_addr_i  in  ADDR_WIDTH  transfer address.
- cmd_wdata_i  in  WORD_SIZE  write data.
- rsp_valid_o  out  1  a response is available.
- rsp_ready_i  in  1  the consumer accepts the response.
- rsp_rdata_o  out  WORD_SIZE  read data; 0 for writes and for aborted transfers.
- rsp_err_o  out  1  captured pslverr, or timeout.
- psel_o, penable_o, pwrite_o  out  1  APB control.
- paddr_o  out  ADDR_WIDTH  APB address.
- pwdata_o  out  WORD_SIZE  APB write data.
- pwakeup_o  out  1  APB wake request.
- pready_i, pslverr_i  in  1  APB slave response.
- prdata_i  in  WORD_SIZE  APB read data.

## Operation
State machine (enum): IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - cmd_ready_o = 1, decoded from state.
  - On cmd_valid_i & cmd_ready_o: latch write, addr and wdata; go to SETUP.
- SETUP:
  - psel_o = 1, penable_o = 0; pwrite_o, paddr_o and pwdata_o driven from the latched command.
  - Unconditionally go to ACCESS.
- ACCESS:
  - psel_o = 1, penable_o = 1; all APB outputs held stable.
  - On pready_i: capture rsp_err_o = pslverr_i.
  - Capture rsp_rdata_o = prdata_i for reads, 0 for writes.
  - Drop psel_o/penable_o and go to RESP.
- RESP:
  - rsp_valid_o = 1 and response held stable until rsp_ready_i; then go to IDLE.
  - No new command is accepted in RESP.
- pwakeup_o = (state != IDLE) | cmd_valid_i. This is the only combinational output path and gives wakeup at least one cycle before psel.
- paddr_o, pwrite_o and pwdata_o keep their last values after a transfer; psel_o and penable_o return to 0.
- Reset:
  - rst_i high forces IDLE on the next edge from any state.
  - Every registered output goes to 0; any in-flight transfer or pending response is discarded.
  - cmd_ready_o is 1 after reset.

## Timing
- Minimum transfer, with pready_i high in the first ACCESS cycle and rsp_ready_i high:
  - cycle 0: accept in IDLE.
  - cycle 1: SETUP.
  - cycle 2: ACCESS, completes.
  - cycle 3: RESP, handshake.
  - cycle 4: IDLE.
- The next command can be accepted in cycle 4, so throughput is 1 transfer per 4 cycles.
- Each cycle of pready_i low extends ACCESS by one cycle.
- Each cycle of rsp_ready_i low extends RESP by one cycle.
- pslverr_i and prdata_i are sampled only in the ACCESS cycle where pready_i = 1.

## Configuration
- APB_MASTER_TIMEOUT_EN defined:
  - A wait counter, width $clog2(TIMEOUT_CYCLES+1), clears in SETUP and increments on each ACCESS cycle with pready_i low.
  - When it reaches TIMEOUT_CYCLES, the transfer aborts: psel_o/penable_o drop and the block enters RESP with rsp_err_o = 1 and rsp_rdata_o = 0.
  - If pready_i rises in the same cycle that the count would reach TIMEOUT_CYCLES, pready_i wins and the transfer completes normally.
- Undefined: ACCESS waits indefinitely for pready_i; the counter logic is absent.

## Structure
- ann_pkg holds:
  - ADDR_WIDTH and WORD_SIZE defaults, shared with the ann slave side.
  - the apb_state_t enum typedef.
- Sub-module apb_watchdog (the wait counter plus a terminal-count flag), instantiated only under APB_MASTER_TIMEOUT_EN.
- Everything else is a single always_ff for state and registers, plus one always_comb for next-state logic.

## Test plan
- Write at addr 0x10 with data 0x1234, pready tied high: psel rises cycle 1, penable cycle 2; rsp_valid in cycle 3 with rsp_err = 0 and rsp_rdata = 0; cmd_ready back in cycle 4.
- Read at addr 0x20, pready low for 3 ACCESS cycles, then high with prdata = 0xBEEF: ACCESS lasts 4 cycles; APB outputs are stable throughout; rsp_rdata = 0xBEEF.
- Read with pslverr = 1 and rsp_ready held low for 5 cycles: rsp_err = 1; response is stable for 5 cycles; cmd_valid held high meanwhile is not accepted.
- With APB_MASTER_TIMEOUT_EN and TIMEOUT_CYCLES = 4, pready never high: abort after 4 ACCESS cycles; rsp_err = 1 and rsp_rdata = 0. Without the macro, psel stays high for 100 or more cycles.
- rst_i pulsed during ACCESS: on the next edge psel, penable and rsp_valid are 0 and cmd_ready is 1; a subsequent write completes normally.
- pwakeup check: cmd_valid rises in IDLE, so pwakeup is 1 in the same cycle and psel is 1 the following cycle. pwakeup returns to 0 in the IDLE cycle after the response handshake.

Source files
------------

// File: rtl/ann_pkg.sv
// Shared definitions for the ann APB link: bus width defaults and the requester state encoding.
package ann_pkg;

  localparam int ANN_ADDR_WIDTH = 8;
  localparam int ANN_WORD_SIZE  = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_state_t;

endpackage

// File: rtl/apb_watchdog.sv
// ACCESS wait counter: clears on SETUP, counts pready-low cycles; expired pulses on the cycle the count
// would reach TIMEOUT_CYCLES. Used by apb_master only when APB_MASTER_TIMEOUT_EN is defined.
module apb_watchdog #(
  parameter int TIMEOUT_CYCLES = 16
)(
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic inc,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (inc) begin
      count <= count + 1'b1;
    end
  end

  // Only a pready-low cycle can expire, so a same-cycle pready always wins.
  assign expired = inc && (count == LAST);

endmodule

// File: rtl/apb_master.sv
// Single-outstanding APB requester: command -> SETUP -> ACCESS -> response, 4 cycles minimum per transfer.
// Stalls in ACCESS on pready and in RESP on rsp_ready; optional abort under APB_MASTER_TIMEOUT_EN.
module apb_master
  import ann_pkg::*;
#(
  parameter int ADDR_WIDTH     = ANN_ADDR_WIDTH,
  parameter int WORD_SIZE      = ANN_WORD_SIZE,
  parameter int TIMEOUT_CYCLES = 16
)(
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic                  cmd_write_i,
  input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
  input  logic [WORD_SIZE-1:0]  cmd_wdata_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [WORD_SIZE-1:0]  rsp_rdata_o,
  output logic                  rsp_err_o,
  output logic                  psel_o,
  output logic                  penable_o,
  output logic                  pwrite_o,
  output logic [ADDR_WIDTH-1:0] paddr_o,
  output logic [WORD_SIZE-1:0]  pwdata_o,
  output logic                  pwakeup_o,
  input  logic                  pready_i,
  input  logic                  pslverr_i,
  input  logic [WORD_SIZE-1:0]  prdata_i
);

  if (TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("apb_master: TIMEOUT_CYCLES must be 1 or more");
  end

  apb_state_t state;
  apb_state_t state_nxt;
  logic       expire;

`ifdef APB_MASTER_TIMEOUT_EN
  apb_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk     (clk_i),
    .rst     (rst_i),
    .clear   (state == SETUP),
    .inc     ((state == ACCESS) && !pready_i),
    .expired (expire)
  );
`else
  assign expire = 1'b0;
`endif

  assign cmd_ready_o = (state == IDLE);
  // Wakeup leads psel by a cycle because cmd_valid feeds it directly.
  assign pwakeup_o   = (state != IDLE) || cmd_valid_i;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cmd_valid_i)          state_nxt = SETUP;
      SETUP:                             state_nxt = ACCESS;
      ACCESS:  if (pready_i || expire)   state_nxt = RESP;
      RESP:    if (rsp_ready_i)          state_nxt = IDLE;
      default:                           state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      psel_o      <= 1'b0;
      penable_o   <= 1'b0;
      pwrite_o    <= 1'b0;
      paddr_o     <= '0;
      pwdata_o    <= '0;
      rsp_valid_o <= 1'b0;
      rsp_rdata_o <= '0;
      rsp_err_o   <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          // The APB address/data registers double as the latched command.
          if (cmd_valid_i) begin
            pwrite_o <= cmd_write_i;
            paddr_o  <= cmd_addr_i;
            pwdata_o <= cmd_wdata_i;
            psel_o   <= 1'b1;
          end
        end
        SETUP: begin
          penable_o <= 1'b1;
        end
        ACCESS: begin
          if (pready_i) begin
            psel_o      <= 1'b0;
            penable_o   <= 1'b0;
            rsp_valid_o <= 1'b1;
            rsp_err_o   <= pslverr_i;
            rsp_rdata_o <= pwrite_o ? '0 : prdata_i;
          end else if (expire) begin
            psel_o      <= 1'b0;
            penable_o   <= 1'b0;
            rsp_valid_o <= 1'b1;
            rsp_err_o   <= 1'b1;
            rsp_rdata_o <= '0;
          end
        end
        RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_o <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master: one task per scenario, cycle-exact expectations computed by hand.
// Build with APB_MASTER_TIMEOUT_EN to exercise the abort path instead of the indefinite wait.
module tb_apb_master;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [7:0]  cmd_addr = '0;
  logic [15:0] cmd_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [15:0] rsp_rdata;
  logic        rsp_err;
  logic        psel, penable, pwrite, pwakeup;
  logic [7:0]  paddr;
  logic [15:0] pwdata;
  logic        pready = 1'b0;
  logic        pslverr = 1'b0;
  logic [15:0] prdata = '0;

  int tests = 0;
  int fails = 0;

  apb_master #(
    .ADDR_WIDTH     (8),
    .WORD_SIZE      (16),
    .TIMEOUT_CYCLES (4)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .cmd_valid_i (cmd_valid),
    .cmd_ready_o (cmd_ready),
    .cmd_write_i (cmd_write),
    .cmd_addr_i  (cmd_addr),
    .cmd_wdata_i (cmd_wdata),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_rdata_o (rsp_rdata),
    .rsp_err_o   (rsp_err),
    .psel_o      (psel),
    .penable_o   (penable),
    .pwrite_o    (pwrite),
    .paddr_o     (paddr),
    .pwdata_o    (pwdata),
    .pwakeup_o   (pwakeup),
    .pready_i    (pready),
    .pslverr_i   (pslverr),
    .prdata_i    (prdata)
  );

  always #5 clk = ~clk;

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic wr, input logic [7:0] addr, input logic [15:0] data);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_wdata = data;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tests++;
    if ({psel, penable, rsp_valid, cmd_ready, pwakeup} !== 5'b00010) begin
      fails++;
      $display("FAIL reset_ctrl: got psel/pen/rvld/crdy/wake=%b required 00010",
               {psel, penable, rsp_valid, cmd_ready, pwakeup});
    end
    tests++;
    if ({rsp_err, rsp_rdata, paddr, pwdata, pwrite} !== 42'd0) begin
      fails++;
      $display("FAIL reset_data: got err=%b rdata=%h paddr=%h pwdata=%h pwrite=%b required all 0",
               rsp_err, rsp_rdata, paddr, pwdata, pwrite);
    end
  endtask

  task automatic test_write();
    pready = 1'b1;
    rsp_ready = 1'b1;
    issue(1'b1, 8'h10, 16'h1234);
    tests++;
    if ({cmd_ready, pwakeup, psel} !== 3'b110) begin
      fails++;
      $display("FAIL wr_c0: got crdy/wake/psel=%b required 110", {cmd_ready, pwakeup, psel});
    end
    tick();
    cmd_valid = 1'b0;
    tests++;
    if ({psel, penable, pwrite, paddr, pwdata} !== {3'b101, 8'h10, 16'h1234}) begin
      fails++;
      $display("FAIL wr_setup: got psel=%b pen=%b pwrite=%b paddr=%h pwdata=%h required 1 0 1 10 1234",
               psel, penable, pwrite, paddr, pwdata);
    end
    tick();
    tests++;
    if ({psel, penable, cmd_ready} !== 3'b110) begin
      fails++;
      $display("FAIL wr_access: got psel/pen/crdy=%b required 110", {psel, penable, cmd_ready});
    end
    tick();
    tests++;
    if ({rsp_valid, rsp_err, rsp_rdata, psel, penable, cmd_ready} !== {2'b10, 16'h0000, 3'b000}) begin
      fails++;
      $display("FAIL wr_resp: got rvld=%b err=%b rdata=%h psel=%b pen=%b crdy=%b required 1 0 0000 0 0 0",
               rsp_valid, rsp_err, rsp_rdata, psel, penable, cmd_ready);
    end
    tick();
    tests++;
    if ({rsp_valid, cmd_ready, pwakeup, paddr, pwdata} !== {3'b010, 8'h10, 16'h1234}) begin
      fails++;
      $display("FAIL wr_idle: got rvld=%b crdy=%b wake=%b paddr=%h pwdata=%h required 0 1 0 10 1234",
               rsp_valid, cmd_ready, pwakeup, paddr, pwdata);
    end
  endtask

  task automatic test_wait_read();
    int bad = 0;
    pready = 1'b0;
    prdata = 16'hDEAD;
    issue(1'b0, 8'h20, 16'h0000);
    tick();
    cmd_valid = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      if (i == 3) begin
        pready = 1'b1;
        prdata = 16'hBEEF;
      end
      if ({psel, penable, pwrite, paddr, rsp_valid} !== {3'b110, 8'h20, 1'b0}) bad++;
      if (i < 3) tick();
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL rd_wait_stable: %0d of 4 ACCESS cycles unstable, required 0", bad);
    end
    tick();
    tests++;
    if ({rsp_valid, rsp_err, rsp_rdata, psel} !== {2'b10, 16'hBEEF, 1'b0}) begin
      fails++;
      $display("FAIL rd_wait_resp: got rvld=%b err=%b rdata=%h psel=%b required 1 0 beef 0",
               rsp_valid, rsp_err, rsp_rdata, psel);
    end
    tick();
    tests++;
    if (cmd_ready !== 1'b1) begin
      fails++;
      $display("FAIL rd_wait_idle: got crdy=%b required 1", cmd_ready);
    end
  endtask

  task automatic test_slverr_stall();
    int bad = 0;
    pready = 1'b1;
    pslverr = 1'b1;
    prdata = 16'h5A5A;
    rsp_ready = 1'b0;
    issue(1'b0, 8'h30, 16'h0000);
    tick();
    cmd_valid = 1'b0;
    tick();
    tick();
    pslverr = 1'b0;
    prdata = 16'h0000;
    issue(1'b1, 8'h31, 16'hFFFF);
    for (int i = 0; i < 5; i++) begin
      if ({rsp_valid, rsp_err, rsp_rdata, cmd_ready, psel} !== {2'b11, 16'h5A5A, 2'b00}) bad++;
      tick();
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL err_stall_stable: %0d of 5 stalled RESP cycles wrong, required 0", bad);
    end
    tests++;
    if ({rsp_valid, rsp_err, paddr} !== {2'b11, 8'h30}) begin
      fails++;
      $display("FAIL err_no_accept: got rvld=%b err=%b paddr=%h required 1 1 30", rsp_valid, rsp_err, paddr);
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    tick();
    tests++;
    if ({rsp_valid, cmd_ready} !== 2'b01) begin
      fails++;
      $display("FAIL err_release: got rvld/crdy=%b required 01", {rsp_valid, cmd_ready});
    end
  endtask

  task automatic test_timeout();
    pready = 1'b0;
    prdata = 16'h7777;
    issue(1'b0, 8'h40, 16'h0000);
    tick();
    cmd_valid = 1'b0;
    tick();
`ifdef APB_MASTER_TIMEOUT_EN
    begin
      int cyc = 0;
      while (psel && cyc < 50) begin
        cyc++;
        tick();
      end
      tests++;
      if (cyc != 4) begin
        fails++;
        $display("FAIL to_len: got %0d ACCESS cycles required 4", cyc);
      end
      tests++;
      if ({rsp_valid, rsp_err, rsp_rdata, penable} !== {2'b11, 16'h0000, 1'b0}) begin
        fails++;
        $display("FAIL to_resp: got rvld=%b err=%b rdata=%h pen=%b required 1 1 0000 0",
                 rsp_valid, rsp_err, rsp_rdata, penable);
      end
    end
`else
    begin
      int held = 0;
      for (int i = 0; i < 100; i++) begin
        if (psel && penable && !rsp_valid) held++;
        tick();
      end
      tests++;
      if (held != 100) begin
        fails++;
        $display("FAIL to_wait: psel/penable held %0d cycles required 100", held);
      end
      pready = 1'b1;
      prdata = 16'h0042;
      tick();
      tests++;
      if ({rsp_valid, rsp_err, rsp_rdata} !== {2'b10, 16'h0042}) begin
        fails++;
        $display("FAIL to_late_ready: got rvld=%b err=%b rdata=%h required 1 0 0042",
                 rsp_valid, rsp_err, rsp_rdata);
      end
    end
`endif
    tick();
    pready = 1'b1;
  endtask

  task automatic test_reset_mid();
    pready = 1'b0;
    issue(1'b1, 8'h50, 16'h1111);
    tick();
    cmd_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tests++;
    if ({psel, penable, rsp_valid, cmd_ready, paddr} !== {4'b0001, 8'h00}) begin
      fails++;
      $display("FAIL rst_mid: got psel=%b pen=%b rvld=%b crdy=%b paddr=%h required 0 0 0 1 00",
               psel, penable, rsp_valid, cmd_ready, paddr);
    end
    pready = 1'b1;
    issue(1'b1, 8'h60, 16'hA5A5);
    tick();
    cmd_valid = 1'b0;
    tick();
    tick();
    tests++;
    if ({rsp_valid, rsp_err, rsp_rdata, paddr, pwdata} !== {2'b10, 16'h0000, 8'h60, 16'hA5A5}) begin
      fails++;
      $display("FAIL rst_recover: got rvld=%b err=%b rdata=%h paddr=%h pwdata=%h required 1 0 0000 60 a5a5",
               rsp_valid, rsp_err, rsp_rdata, paddr, pwdata);
    end
    tick();
  endtask

  task automatic test_pwakeup();
    pready = 1'b1;
    rsp_ready = 1'b1;
    tests++;
    if ({pwakeup, cmd_ready} !== 2'b01) begin
      fails++;
      $display("FAIL wake_idle: got wake/crdy=%b required 01", {pwakeup, cmd_ready});
    end
    issue(1'b0, 8'h70, 16'h0000);
    tests++;
    if ({pwakeup, psel} !== 2'b10) begin
      fails++;
      $display("FAIL wake_lead: got wake/psel=%b required 10", {pwakeup, psel});
    end
    tick();
    cmd_valid = 1'b0;
    #1;
    tests++;
    if ({pwakeup, psel} !== 2'b11) begin
      fails++;
      $display("FAIL wake_setup: got wake/psel=%b required 11", {pwakeup, psel});
    end
    tick();
    tick();
    tests++;
    if ({pwakeup, rsp_valid} !== 2'b11) begin
      fails++;
      $display("FAIL wake_resp: got wake/rvld=%b required 11", {pwakeup, rsp_valid});
    end
    tick();
    tests++;
    if ({pwakeup, cmd_ready} !== 2'b01) begin
      fails++;
      $display("FAIL wake_drop: got wake/crdy=%b required 01", {pwakeup, cmd_ready});
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_wait_read();
    test_slverr_stall();
    test_timeout();
    test_reset_mid();
    test_pwakeup();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
